// File: rtl/debounce_strobe_pkg.sv
// debounce_strobe_pkg
//   Shared definitions for the debounce/strobe block.
//   - EDGE_RISE / EDGE_FALL / EDGE_BOTH : strobe trigger encodings
//   - edge_match()  : does an accepted new level match the trigger mode
//   - cnt_width()   : debounce counter width, never below 1 bit
package debounce_strobe_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // new_level is the value q is about to take, so a rise means new_level==1.
  function automatic logic edge_match(input int mode, input logic new_level);
    case (mode)
      EDGE_RISE: return new_level;
      EDGE_FALL: return !new_level;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One input bit: synchroniser chain, debounce counter, stable level and
//   edge strobe.
//   Ports:
//     clk         in   clock, all state on rising edge
//     rst         in   synchronous active-low reset
//     d           in   raw asynchronous level
//     en          in   strobe enable (never blocks q updates)
//     q           out  registered debounced level
//     strobe      out  registered one-cycle pulse on an accepted matching edge
//     strobe_next out  combinational value strobe takes at the next edge,
//                      used by the parent to register strobe_any alongside
module debounce_channel
  import debounce_strobe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q,
  output logic strobe,
  output logic strobe_next
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   q_reg;
  logic                   q_next;
  logic                   strobe_reg;
  logic                   accept;
  logic                   s;

  assign s = sync_reg[SYNC_STAGES-1];

  // Any cycle where s agrees with q (including a one-cycle glitch mid-count)
  // drops the count back to 0. Acceptance happens on the cycle the count
  // has already reached its last value, so the counter never wraps.
  always_comb begin
    cnt_next    = '0;
    q_next      = q_reg;
    accept      = 1'b0;
    if (s != q_reg) begin
      if (cnt_reg == CNT_LAST) begin
        accept = 1'b1;
        q_next = s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    strobe_next = accept && en && edge_match(EDGE_MODE, s);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      q_reg      <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], d};
      cnt_reg    <= cnt_next;
      q_reg      <= q_next;
      strobe_reg <= strobe_next;
    end
  end

  assign q      = q_reg;
  assign strobe = strobe_reg;

endmodule

// File: rtl/debounce_strobe.sv
// debounce_strobe
//   Multi-channel debouncer with per-channel edge strobes.
//   Ports:
//     clk        in   clock, all state on rising edge
//     rst        in   synchronous active-low reset
//     d          in   [CHANNELS] raw asynchronous levels
//     en         in   [CHANNELS] per-channel strobe enable
//     q          out  [CHANNELS] debounced stable levels
//     strobe     out  [CHANNELS] one-cycle pulses on accepted edges
//     strobe_any out  OR of strobe, registered in the same edge
module debounce_strobe
  import debounce_strobe_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] strobe,
  output logic                strobe_any
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_strobe: CHANNELS must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
    $error("debounce_strobe: DEBOUNCE_CYCLES must be 1..65535");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_strobe: SYNC_STAGES must be 2..4");
  end
  if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_BOTH) begin : g_bad_mode
    $error("debounce_strobe: EDGE_MODE must be EDGE_RISE, EDGE_FALL or EDGE_BOTH");
  end

  logic [CHANNELS-1:0] strobe_next;
  logic                strobe_any_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .d           (d[gi]),
      .en          (en[gi]),
      .q           (q[gi]),
      .strobe      (strobe[gi]),
      .strobe_next (strobe_next[gi])
    );
  end

  // Built from the channels' next-strobe values so it lands in the same
  // cycle as the strobe bits rather than one cycle behind them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      strobe_any_reg <= 1'b0;
    end else begin
      strobe_any_reg <= |strobe_next;
    end
  end

  assign strobe_any = strobe_any_reg;

endmodule
